// File: rtl/axi_rw.sv
// -----------------------------------------------------------------------------
// axi_rw
//
// Bridges a simple single-access requester port onto an AXI4 master. Each
// request is one single-beat burst: a read goes AR -> R, a write goes
// AW + W -> B. At most one transaction is in flight; completion is a
// one-cycle rw_ready pulse with the response code and, for reads, the
// lane-aligned, zero-extended read data.
//
// Ports
//   clock, reset          single clock, asynchronous active-high reset
//   rw_valid / rw_ready   request held by requester until the completion pulse
//   rw_req                0 = read, 1 = write
//   rw_addr, rw_size      byte address; size 00/01/10/11 = 1/2/4/8 bytes
//   rw_id                 transaction ID driven onto ar_id / aw_id
//   data_write            write data, LSB-aligned
//   data_read, rw_resp    registered read data (LSB-aligned) and AXI response
//   aw_* / w_* / b_*      AXI write address, write data and write response
//   ar_* / r_*            AXI read address and read data
// -----------------------------------------------------------------------------
module axi_rw #(
   parameter int RW_DATA_WIDTH  = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4
) (
   input  logic                        clock,
   input  logic                        reset,

   // requester side
   input  logic                        rw_valid,
   output logic                        rw_ready,
   input  logic                        rw_req,
   input  logic [AXI_DATA_WIDTH-1:0]   rw_addr,
   input  logic [1:0]                  rw_size,
   input  logic [RW_DATA_WIDTH-1:0]    data_write,
   output logic [RW_DATA_WIDTH-1:0]    data_read,
   output logic [1:0]                  rw_resp,
   input  logic [3:0]                  rw_id,

   // AXI write address
   output logic                        aw_valid,
   input  logic                        aw_ready,
   output logic [AXI_DATA_WIDTH-1:0]   aw_addr,
   output logic [AXI_ID_WIDTH-1:0]     aw_id,
   output logic [7:0]                  aw_len,
   output logic [2:0]                  aw_size,
   output logic [1:0]                  aw_burst,

   // AXI write data
   output logic                        w_valid,
   input  logic                        w_ready,
   output logic [AXI_DATA_WIDTH-1:0]   w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   output logic                        w_last,

   // AXI write response
   input  logic                        b_valid,
   output logic                        b_ready,
   input  logic [1:0]                  b_resp,
   input  logic [AXI_ID_WIDTH-1:0]     b_id,

   // AXI read address
   output logic                        ar_valid,
   input  logic                        ar_ready,
   output logic [AXI_DATA_WIDTH-1:0]   ar_addr,
   output logic [AXI_ID_WIDTH-1:0]     ar_id,
   output logic [7:0]                  ar_len,
   output logic [2:0]                  ar_size,
   output logic [1:0]                  ar_burst,

   // AXI read data
   input  logic                        r_valid,
   output logic                        r_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   r_data,
   input  logic [1:0]                  r_resp,
   input  logic                        r_last,
   input  logic [AXI_ID_WIDTH-1:0]     r_id
);

   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] R_ADDR = 3'd1;
   localparam logic [2:0] R_DATA = 3'd2;
   localparam logic [2:0] W_ADDR = 3'd3;
   localparam logic [2:0] W_RESP = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam logic [1:0] BURST_INCR = 2'b01;

   logic [2:0]                state_q, state_d;
   logic [AXI_DATA_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]                size_q, size_d;
   logic [3:0]                id_q, id_d;
   logic [RW_DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                      ar_valid_q, ar_valid_d;
   logic                      aw_valid_q, aw_valid_d;
   logic                      w_valid_q, w_valid_d;
   logic [RW_DATA_WIDTH-1:0]  data_read_q, data_read_d;
   logic [1:0]                resp_q, resp_d;

   // Byte-lane placement derived from the latched address and size.
   logic [5:0]                lane_shift;
   logic [AXI_DATA_WIDTH-1:0] size_mask;
   logic [AXI_DATA_WIDTH-1:0] rdata_aligned;
   logic [7:0]                strb_base;
   logic [7:0]                strb_shifted;

   // ID/last on the response channels are deliberately not checked.
   logic                      unused_axi_sideband;
   assign unused_axi_sideband = ^{r_id, b_id, r_last};

   assign lane_shift = {addr_q[2:0], 3'b000};

   always_comb begin
      size_mask = '1;
      strb_base = 8'hFF;
      case (size_q)
         2'b00: begin
            size_mask = AXI_DATA_WIDTH'(8'hFF);
            strb_base = 8'h01;
         end
         2'b01: begin
            size_mask = AXI_DATA_WIDTH'(16'hFFFF);
            strb_base = 8'h03;
         end
         2'b10: begin
            size_mask = AXI_DATA_WIDTH'(32'hFFFF_FFFF);
            strb_base = 8'h0F;
         end
         default: begin
            size_mask = '1;
            strb_base = 8'hFF;
         end
      endcase
   end

   // Bits shifted past lane 7 are dropped, so a misaligned access never
   // spills into a second beat.
   assign strb_shifted  = strb_base << addr_q[2:0];
   assign rdata_aligned = (r_data >> lane_shift) & size_mask;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      id_d        = id_q;
      wdata_d     = wdata_q;
      ar_valid_d  = ar_valid_q;
      aw_valid_d  = aw_valid_q;
      w_valid_d   = w_valid_q;
      data_read_d = data_read_q;
      resp_d      = resp_q;

      case (state_q)
         IDLE: begin
            if (rw_valid) begin
               addr_d  = rw_addr;
               size_d  = rw_size;
               id_d    = rw_id;
               wdata_d = data_write;
               if (rw_req) begin
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  state_d    = W_ADDR;
               end else begin
                  ar_valid_d = 1'b1;
                  state_d    = R_ADDR;
               end
            end
         end

         R_ADDR: begin
            if (ar_valid_q && ar_ready) begin
               ar_valid_d = 1'b0;
               state_d    = R_DATA;
            end
         end

         R_DATA: begin
            if (r_valid) begin
               data_read_d = RW_DATA_WIDTH'(rdata_aligned);
               resp_d      = r_resp;
               state_d     = DONE;
            end
         end

         W_ADDR: begin
            // AW and W retire independently; leave once neither is pending,
            // which covers both handshakes landing on the same edge.
            if (aw_valid_q && aw_ready) begin
               aw_valid_d = 1'b0;
            end
            if (w_valid_q && w_ready) begin
               w_valid_d = 1'b0;
            end
            if (!aw_valid_d && !w_valid_d) begin
               state_d = W_RESP;
            end
         end

         W_RESP: begin
            if (b_valid) begin
               resp_d  = b_resp;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d    = IDLE;
            ar_valid_d = 1'b0;
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         id_q        <= '0;
         wdata_q     <= '0;
         ar_valid_q  <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         data_read_q <= '0;
         resp_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         id_q        <= id_d;
         wdata_q     <= wdata_d;
         ar_valid_q  <= ar_valid_d;
         aw_valid_q  <= aw_valid_d;
         w_valid_q   <= w_valid_d;
         data_read_q <= data_read_d;
         resp_q      <= resp_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: every AXI field comes from latched request state
   // ---------------------------------------------------------------------
   assign rw_ready  = (state_q == DONE);
   assign data_read = data_read_q;
   assign rw_resp   = resp_q;

   assign ar_valid  = ar_valid_q;
   assign ar_addr   = addr_q;
   assign ar_id     = AXI_ID_WIDTH'(id_q);
   assign ar_len    = 8'd0;
   assign ar_size   = {1'b0, size_q};
   assign ar_burst  = BURST_INCR;
   assign r_ready   = (state_q == R_DATA);

   assign aw_valid  = aw_valid_q;
   assign aw_addr   = addr_q;
   assign aw_id     = AXI_ID_WIDTH'(id_q);
   assign aw_len    = 8'd0;
   assign aw_size   = {1'b0, size_q};
   assign aw_burst  = BURST_INCR;

   assign w_valid   = w_valid_q;
   assign w_data    = AXI_DATA_WIDTH'(wdata_q) << lane_shift;
   // Strobes are qualified by w_valid so the idle/reset bus reads all-zero.
   assign w_strb    = w_valid_q ? STRB_WIDTH'(strb_shifted) : '0;
   assign w_last    = w_valid_q;
   assign b_ready   = (state_q == W_RESP);

endmodule

// File: doc/axi_rw.md
AXI_RW -- requirements
Module: axi_rw

Interface
REQ-001 SHALL have parameter RW_DATA_WIDTH, default 64, width of the requester data buses.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, width of AXI addresses and data.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, width of the AXI ID fields.
REQ-004 SHALL have port clock, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rw_valid, input, 1, requester holds high until rw_ready.
REQ-007 SHALL have port rw_ready, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port rw_req, input, 1, 0 = read, 1 = write.
REQ-009 SHALL have port rw_addr, input, AXI_DATA_WIDTH, byte address.
REQ-010 SHALL have port rw_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = double.
REQ-011 SHALL have ports data_write (input) and data_read (output), each RW_DATA_WIDTH, LSB-aligned.
REQ-012 SHALL have ports rw_resp (output, 2, AXI response code) and rw_id (input, 4, transaction ID).
REQ-013 SHALL have the AXI AW channel: aw_valid out 1, aw_ready in 1, aw_addr out AXI_DATA_WIDTH, aw_id out AXI_ID_WIDTH, aw_len out 8, aw_size out 3, aw_burst out 2.
REQ-014 SHALL have the AXI W channel: w_valid out 1, w_ready in 1, w_data out AXI_DATA_WIDTH, w_strb out AXI_DATA_WIDTH/8, w_last out 1.
REQ-015 SHALL have the AXI B channel: b_valid in 1, b_ready out 1, b_resp in 2, b_id in AXI_ID_WIDTH.
REQ-016 SHALL have the AXI AR channel: ar_valid out 1, ar_ready in 1, ar_addr out AXI_DATA_WIDTH, ar_id out AXI_ID_WIDTH, ar_len out 8, ar_size out 3, ar_burst out 2.
REQ-017 SHALL have the AXI R channel: r_valid in 1, r_ready out 1, r_data in AXI_DATA_WIDTH, r_resp in 2, r_last in 1, r_id in AXI_ID_WIDTH.

Function
REQ-018 SHALL implement states IDLE, R_ADDR, R_DATA, W_ADDR, W_RESP, DONE, with one transaction outstanding at most.
REQ-019 SHALL, in IDLE with rw_valid=1, latch rw_req, rw_addr, rw_size, rw_id and data_write, and go to R_ADDR (rw_req=0) or W_ADDR (rw_req=1).
REQ-020 SHALL drive ar_valid/aw_valid/w_valid from registers, first high the cycle after acceptance.
REQ-021 SHALL drive all AXI address/ID/data fields from latched values only, stable while the corresponding valid is high.
REQ-022 SHALL drive every burst as a single beat: *_len=0, *_burst=01 (INCR), w_last=1 with w_valid, *_size={1'b0,latched size}.
REQ-023 SHALL, in R_ADDR, hold ar_valid until ar_ready, then go to R_DATA.
REQ-024 SHALL, in R_DATA, hold r_ready=1 and, on r_valid, register data_read=r_data>>(8*addr[2:0]) zero-extended above the access size, register rw_resp=r_resp, and go to DONE.
REQ-025 SHALL, in W_ADDR, raise aw_valid and w_valid together, drop each independently on its own handshake, and go to W_RESP once both have completed (including the same cycle).
REQ-026 SHALL drive w_data=data_write<<(8*addr[2:0]), and w_strb=(size mask 0x01/0x03/0x0F/0xFF)<<addr[2:0] truncated to 8 bits.
REQ-027 SHALL, in W_RESP, hold b_ready=1 and, on b_valid, register rw_resp=b_resp and go to DONE; data_read SHALL hold its previous value.
REQ-028 SHALL assert rw_ready=1 for exactly the DONE cycle, then return to IDLE; rw_valid in DONE SHALL be ignored (minimum one IDLE cycle between transactions).
REQ-029 SHALL pass rw_resp values SLVERR/DECERR through unchanged, without retry.
REQ-030 SHALL ignore r_id/b_id/r_last mismatches (no checking).
REQ-031 SHALL treat a change of rw_valid or other request inputs after acceptance as having no effect until IDLE.

Reset
REQ-032 SHALL, while reset=1 (asynchronous), force state IDLE; all AXI valid/ready outputs 0; rw_ready=0; data_read=0; rw_resp=0; latched fields 0.
REQ-033 SHALL abandon any in-flight transaction on reset mid-operation, with no completion pulse.

Verification
REQ-034 SHALL verify a read of addr 0x8000_0004, size 10, r_data 0x1122_3344_5566_7788: data_read=0x0000_0000_1122_3344, rw_resp=00, one rw_ready pulse.
REQ-035 SHALL verify a write of addr 0x8000_0003, size 00, data_write 0xAB: w_data byte3=0xAB, w_strb=0x08, aw_size=000, w_last=1.
REQ-036 SHALL verify a write with w_ready 3 cycles before aw_ready: each valid drops on its own handshake; b_resp=10 gives rw_resp=10.
REQ-037 SHALL verify that rw_valid held high through DONE: the next ar_valid rises no earlier than 2 cycles after rw_ready.
REQ-038 SHALL verify reset asserted in R_DATA: all outputs 0 immediately, IDLE after release, no rw_ready.
REQ-039 SHALL verify back-to-back read then write with random ready/valid delays 0-5: payloads and responses match a reference model.
